// File: rtl/pipelined_write_rx.sv
// Receiver for the pipelined-write link: parses one command cycle, collects
// 1..MAX_WR_CYCLES data beats and emits one wide write plus wdone/err pulses.
module pipelined_write_rx #(
  parameter int MAX_WR_CYCLES  = 4,
  parameter int WR_WIDTH       = 8,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic [9:0]                        in_cyc,
  output logic                              wr_vld,
  output logic [MAX_WR_CYCLES*WR_WIDTH-1:0] wr_dat,
  output logic [2:0]                        wr_len,
  output logic [2:0]                        wr_type,
  output logic                              wdone,
  output logic                              err,
  output logic                              busy
);

  localparam int CW = $clog2(MAX_WR_CYCLES + 1);
  localparam int AW = (MAX_WR_CYCLES > 1) ? $clog2(MAX_WR_CYCLES) : 1;
  localparam int IW = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [1:0] CT_IDLE  = 2'd0;
  localparam logic [1:0] CT_VALID = 2'd1;
  localparam logic [1:0] CT_DONE  = 2'd2;

  typedef enum logic {S_CMD, S_DATA} state_e;

  state_e                                   state_q;
  logic [CW-1:0]                            cnt_q;
  logic [CW-1:0]                            exp_q;
  logic [IW-1:0]                            idle_q;
  logic [2:0]                               type_q;
  logic [MAX_WR_CYCLES-1:0][WR_WIDTH-1:0]   beats_q;

  // Command fields
  logic       cmd_val;
  logic [3:0] cmd_rsvd;
  logic [1:0] cmd_num;
  logic [2:0] cmd_type;
  // Data fields
  logic [1:0]          ctype;
  logic [WR_WIDTH-1:0] dat;

  assign cmd_val  = in_cyc[5];
  assign cmd_rsvd = in_cyc[9:6];
  assign cmd_num  = in_cyc[4:3];
  assign cmd_type = in_cyc[2:0];
  assign ctype    = in_cyc[9:8];
  assign dat      = in_cyc[WR_WIDTH-1:0];

  logic                                   multi, single, last, fin, tmo;
  logic [CW-1:0]                          cnt_inc;
  logic [MAX_WR_CYCLES-1:0][WR_WIDTH-1:0] beats_d;

  // Out-of-range write types fall back to STD, so neither wdone mode matches.
  assign multi   = (type_q == 3'd1);
  assign single  = (type_q == 3'd2);
  assign cnt_inc = cnt_q + CW'(1);
  assign last    = (cnt_inc == exp_q);
  assign fin     = (ctype == CT_DONE) || ((ctype == CT_VALID) && last);
  assign tmo     = (idle_q + IW'(1)) == IW'(TIMEOUT_CYCLES);

  always_comb begin
    beats_d = beats_q;
    beats_d[cnt_q[AW-1:0]] = dat;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_CMD;
      cnt_q   <= '0;
      exp_q   <= '0;
      idle_q  <= '0;
      type_q  <= '0;
      beats_q <= '0;
      wr_vld  <= 1'b0;
      wr_dat  <= '0;
      wr_len  <= '0;
      wr_type <= '0;
      wdone   <= 1'b0;
      err     <= 1'b0;
      busy    <= 1'b0;
    end else begin
      wr_vld <= 1'b0;
      wdone  <= 1'b0;
      err    <= 1'b0;
      case (state_q)
        S_CMD: begin
          if (cmd_val) begin
            exp_q   <= (cmd_num == 2'd0) ? CW'(MAX_WR_CYCLES) : CW'(cmd_num);
            type_q  <= cmd_type;
            cnt_q   <= '0;
            idle_q  <= '0;
            beats_q <= '0;
            state_q <= S_DATA;
            busy    <= 1'b1;
            err     <= (cmd_rsvd != 4'd0) || (cmd_type > 3'd2);
          end
        end
        S_DATA: begin
          if (ctype == CT_VALID || ctype == CT_DONE) begin
            beats_q <= beats_d;
            cnt_q   <= cnt_inc;
            idle_q  <= '0;
            wdone   <= multi;
            // VALID on the last expected beat and DONE before it are both violations.
            err     <= (ctype == CT_VALID) ? last : !last;
          end else begin
            err <= (ctype == 2'd3) || tmo;
            if (tmo) begin
              state_q <= S_CMD;
              busy    <= 1'b0;
            end else begin
              idle_q <= idle_q + IW'(1);
            end
          end
          if (fin) begin
            wr_vld  <= 1'b1;
            wr_dat  <= beats_d;
            wr_len  <= 3'(cnt_inc);
            wr_type <= type_q;
            wdone   <= multi || single;
            state_q <= S_CMD;
            busy    <= 1'b0;
          end
        end
        default: state_q <= S_CMD;
      endcase
    end
  end

endmodule

// File: tb/tb_pipelined_write_rx.sv
// Directed bench for pipelined_write_rx with hand-computed expectations.
module tb_pipelined_write_rx;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [9:0]  in_cyc = '0;
  logic        wr_vld, wdone, err, busy;
  logic [31:0] wr_dat;
  logic [2:0]  wr_len, wr_type;

  int vectors = 0;
  int miscompares = 0;

  pipelined_write_rx dut (
    .clk(clk), .rst_n(rst_n), .in_cyc(in_cyc),
    .wr_vld(wr_vld), .wr_dat(wr_dat), .wr_len(wr_len), .wr_type(wr_type),
    .wdone(wdone), .err(err), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [9:0] cmd(input logic [1:0] num, input logic [2:0] t,
                                     input logic [3:0] rsvd = 4'd0);
    return {rsvd, 1'b1, num, t};
  endfunction

  function automatic logic [9:0] dc(input logic [1:0] t, input logic [7:0] d);
    return {t, d};
  endfunction

  task automatic step(input logic [9:0] c);
    in_cyc = c;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // {wr_vld, wdone, err, busy}
  task automatic ctl(input string tag, input logic [3:0] exp);
    chk(tag, {60'd0, wr_vld, wdone, err, busy}, {60'd0, exp});
  endtask

  task automatic wr(input string tag, input logic [31:0] d, input logic [2:0] l, input logic [2:0] t);
    chk({tag, "_dat"}, {32'd0, wr_dat}, {32'd0, d});
    chk({tag, "_len"}, {61'd0, wr_len}, {61'd0, l});
    chk({tag, "_type"}, {61'd0, wr_type}, {61'd0, t});
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    ctl("reset_ctl", 4'b0000);
    wr("reset", 32'h0, 3'd0, 3'd0);
    rst_n = 1'b1;

    // STD, 2 beats
    step(cmd(2'd2, 3'd0));        ctl("std_cmd", 4'b0001);
    step(dc(2'd1, 8'hAA));        ctl("std_v0", 4'b0001);
    step(dc(2'd2, 8'h55));        ctl("std_done", 4'b1000);
    wr("std", 32'h0000_55AA, 3'd2, 3'd0);
    step(10'h000);                ctl("std_after", 4'b0000);

    // MULTI_WDONE, 4 beats via num_cycles=0
    step(cmd(2'd0, 3'd1));        ctl("multi_cmd", 4'b0001);
    step(dc(2'd1, 8'h11));        ctl("multi_v0", 4'b0101);
    step(dc(2'd1, 8'h22));        ctl("multi_v1", 4'b0101);
    step(dc(2'd1, 8'h33));        ctl("multi_v2", 4'b0101);
    step(dc(2'd2, 8'h44));        ctl("multi_done", 4'b1100);
    wr("multi", 32'h4433_2211, 3'd4, 3'd1);

    // SINGLE_WDONE with idle bubbles
    step(cmd(2'd3, 3'd2));        ctl("single_cmd", 4'b0001);
    step(dc(2'd1, 8'h01));        ctl("single_v0", 4'b0001);
    for (int i = 0; i < 5; i++) begin
      step(dc(2'd0, 8'h00));      ctl("single_idle", 4'b0001);
    end
    step(dc(2'd1, 8'h02));        ctl("single_v1", 4'b0001);
    step(dc(2'd2, 8'h03));        ctl("single_done", 4'b1100);
    wr("single", 32'h0003_0201, 3'd3, 3'd2);

    // Early DONE
    step(cmd(2'd3, 3'd0));        ctl("early_cmd", 4'b0001);
    step(dc(2'd1, 8'h10));        ctl("early_v0", 4'b0001);
    step(dc(2'd2, 8'h20));        ctl("early_done", 4'b1010);
    wr("early", 32'h0000_2010, 3'd2, 3'd0);

    // Timeout after 16 idle cycles
    step(cmd(2'd1, 3'd0));        ctl("tmo_cmd", 4'b0001);
    for (int i = 0; i < 15; i++) begin
      step(dc(2'd0, 8'h00));      ctl("tmo_idle", 4'b0001);
    end
    step(dc(2'd0, 8'h00));        ctl("tmo_abort", 4'b0010);
    wr("tmo_hold", 32'h0000_2010, 3'd2, 3'd0);
    step(10'h000);                ctl("tmo_quiet", 4'b0000);
    step(cmd(2'd1, 3'd1));        ctl("post_tmo_cmd", 4'b0001);
    step(dc(2'd2, 8'h77));        ctl("post_tmo_done", 4'b1100);
    wr("post_tmo", 32'h0000_0077, 3'd1, 3'd1);

    // Back-to-back writes
    step(cmd(2'd1, 3'd0));        ctl("b2b_cmd0", 4'b0001);
    step(dc(2'd2, 8'h5A));        ctl("b2b_done0", 4'b1000);
    chk("b2b_dat0", {32'd0, wr_dat}, 64'h5A);
    step(cmd(2'd2, 3'd0));        ctl("b2b_cmd1", 4'b0001);
    step(dc(2'd1, 8'h01));        ctl("b2b_v1", 4'b0001);
    step(dc(2'd2, 8'h02));        ctl("b2b_done1", 4'b1000);
    wr("b2b1", 32'h0000_0201, 3'd2, 3'd0);

    // Protocol errors
    step(cmd(2'd1, 3'd0, 4'h1));  ctl("rsvd_cmd", 4'b0011);
    step(dc(2'd2, 8'h33));        ctl("rsvd_done", 4'b1000);
    step(cmd(2'd1, 3'd5));        ctl("badtype_cmd", 4'b0011);
    step(dc(2'd2, 8'h44));        ctl("badtype_done", 4'b1000);
    chk("badtype_dat", {32'd0, wr_dat}, 64'h44);
    step(cmd(2'd1, 3'd0));        ctl("lastvalid_cmd", 4'b0001);
    step(dc(2'd1, 8'h66));        ctl("lastvalid", 4'b1010);
    wr("lastvalid", 32'h0000_0066, 3'd1, 3'd0);
    step(cmd(2'd1, 3'd0));        ctl("ct3_cmd", 4'b0001);
    step(dc(2'd3, 8'h00));        ctl("ct3", 4'b0011);
    step(dc(2'd2, 8'h12));        ctl("ct3_done", 4'b1000);
    chk("ct3_dat", {32'd0, wr_dat}, 64'h12);

    // Reset mid-write
    step(cmd(2'd2, 3'd1));        ctl("rst_cmd", 4'b0001);
    step(dc(2'd1, 8'h99));        ctl("rst_v0", 4'b0101);
    rst_n = 1'b0;
    #1;
    ctl("rst_mid_ctl", 4'b0000);
    wr("rst_mid", 32'h0, 3'd0, 3'd0);
    in_cyc = dc(2'd2, 8'h88);
    @(negedge clk);
    rst_n = 1'b1;
    step(dc(2'd2, 8'h88));        ctl("rst_after0", 4'b0000);
    step(dc(2'd2, 8'h88));        ctl("rst_after1", 4'b0000);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
